// File: rtl/video_mnist_colorizer.sv
// video_mnist_colorizer: per-pixel AXI4-Stream colorizer for the MNIST video pipeline.
// Each pixel becomes a per-digit color, a black/white binary rendering, or the source
// pixel. MODE, TH and COLOR0..9 are programmed over a zero-wait Wishbone slave.
// Optional feature macro: VIDEO_MNIST_COLOR_FRAME_SYNC_EN. When it is defined,
// register changes take effect only from the next frame-start beat.
module video_mnist_colorizer #(
    parameter int           DATA_WIDTH      = 8,
    parameter int           TUSER_WIDTH     = 1,
    parameter int           TNUMBER_WIDTH   = 4,
    parameter int           TCOUNT_WIDTH    = 1,
    parameter int           WB_ADR_WIDTH    = 8,
    parameter int           WB_DAT_WIDTH    = 32,
    parameter int           WB_SEL_WIDTH    = WB_DAT_WIDTH / 8,
    parameter logic [1:0]   INIT_PARAM_MODE = 2'b10,
    parameter int           INIT_PARAM_TH   = 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [TUSER_WIDTH-1:0]    s_axi4s_tuser,
    input  logic                      s_axi4s_tlast,
    input  logic [TNUMBER_WIDTH-1:0]  s_axi4s_tnumber,
    input  logic [TCOUNT_WIDTH-1:0]   s_axi4s_tcount,
    input  logic [4*DATA_WIDTH-1:0]   s_axi4s_tdata,
    input  logic                      s_axi4s_tbinary,
    input  logic                      s_axi4s_tvalid,
    output logic                      s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
    output logic                      m_axi4s_tlast,
    output logic [4*DATA_WIDTH-1:0]   m_axi4s_tdata,
    output logic                      m_axi4s_tvalid,
    input  logic                      m_axi4s_tready,
    input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
    input  logic                      s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]   s_wb_sel_i,
    input  logic                      s_wb_stb_i,
    output logic                      s_wb_ack_o
);

    localparam int PIX_W = 4 * DATA_WIDTH;

    logic [1:0]              mode_reg;
    logic [TCOUNT_WIDTH-1:0] th_reg;
    logic [23:0]             color_reg [10];

    logic [1:0]              eff_mode;
    logic [TCOUNT_WIDTH-1:0] eff_th;
    logic [23:0]             eff_color [10];

    logic [WB_DAT_WIDTH-1:0] wb_mask;
    logic                    wb_wr;
    logic                    s_accept;
    logic                    color_hit;
    logic [PIX_W-1:0]        pix;

    function automatic logic [23:0] default_color(input int unsigned idx);
        case (idx)
            0:       return 24'h000000;
            1:       return 24'h804000;
            2:       return 24'hFF0000;
            3:       return 24'hFF8000;
            4:       return 24'hFFFF00;
            5:       return 24'h00FF00;
            6:       return 24'h0000FF;
            7:       return 24'h8000FF;
            8:       return 24'h808080;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic [WB_DAT_WIDTH-1:0] merge(input logic [WB_DAT_WIDTH-1:0] old,
                                                      input logic [WB_DAT_WIDTH-1:0] dat,
                                                      input logic [WB_DAT_WIDTH-1:0] mask);
        return (old & ~mask) | (dat & mask);
    endfunction

    assign s_wb_ack_o     = s_wb_stb_i;
    assign wb_wr          = s_wb_stb_i && s_wb_we_i;
    assign s_axi4s_tready = !m_axi4s_tvalid || m_axi4s_tready;
    assign s_accept       = s_axi4s_tvalid && s_axi4s_tready;

    // Expand the byte selects into a bit mask for the write merge.
    always_comb begin
        wb_mask = '0;
        for (int unsigned i = 0; i < WB_SEL_WIDTH; i++) begin
            wb_mask[i*8 +: 8] = {8{s_wb_sel_i[i]}};
        end
    end

    // Register file: byte-masked writes land at the clock edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mode_reg <= INIT_PARAM_MODE;
            th_reg   <= TCOUNT_WIDTH'(INIT_PARAM_TH);
            for (int unsigned i = 0; i < 10; i++) begin
                color_reg[i] <= default_color(i);
            end
        end else if (wb_wr) begin
            if (s_wb_adr_i == WB_ADR_WIDTH'(0)) begin
                mode_reg <= 2'(merge(WB_DAT_WIDTH'(mode_reg), s_wb_dat_i, wb_mask));
            end
            if (s_wb_adr_i == WB_ADR_WIDTH'(1)) begin
                th_reg <= TCOUNT_WIDTH'(merge(WB_DAT_WIDTH'(th_reg), s_wb_dat_i, wb_mask));
            end
            for (int unsigned i = 0; i < 10; i++) begin
                if (s_wb_adr_i == WB_ADR_WIDTH'(16 + i)) begin
                    color_reg[i] <= 24'(merge(WB_DAT_WIDTH'(color_reg[i]), s_wb_dat_i, wb_mask));
                end
            end
        end
    end

    // Combinational read mux; unmapped addresses return zero.
    always_comb begin
        s_wb_dat_o = '0;
        if (s_wb_adr_i == WB_ADR_WIDTH'(0)) begin
            s_wb_dat_o = WB_DAT_WIDTH'(mode_reg);
        end
        if (s_wb_adr_i == WB_ADR_WIDTH'(1)) begin
            s_wb_dat_o = WB_DAT_WIDTH'(th_reg);
        end
        for (int unsigned i = 0; i < 10; i++) begin
            if (s_wb_adr_i == WB_ADR_WIDTH'(16 + i)) begin
                s_wb_dat_o = WB_DAT_WIDTH'(color_reg[i]);
            end
        end
    end

`ifdef VIDEO_MNIST_COLOR_FRAME_SYNC_EN
    logic                    frame_load;
    logic [1:0]              shadow_mode;
    logic [TCOUNT_WIDTH-1:0] shadow_th;
    logic [23:0]             shadow_color [10];

    assign frame_load = s_accept && s_axi4s_tuser[0];

    // Shadow copies follow the live registers only on an accepted frame-start beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shadow_mode <= INIT_PARAM_MODE;
            shadow_th   <= TCOUNT_WIDTH'(INIT_PARAM_TH);
            for (int unsigned i = 0; i < 10; i++) begin
                shadow_color[i] <= default_color(i);
            end
        end else if (frame_load) begin
            shadow_mode <= mode_reg;
            shadow_th   <= th_reg;
            for (int unsigned i = 0; i < 10; i++) begin
                shadow_color[i] <= color_reg[i];
            end
        end
    end

    // The frame-start beat itself already sees the values being loaded.
    always_comb begin
        eff_mode = frame_load ? mode_reg : shadow_mode;
        eff_th   = frame_load ? th_reg   : shadow_th;
        for (int unsigned i = 0; i < 10; i++) begin
            eff_color[i] = frame_load ? color_reg[i] : shadow_color[i];
        end
    end
`else
    // Selection reads the live registers.
    always_comb begin
        eff_mode = mode_reg;
        eff_th   = th_reg;
        for (int unsigned i = 0; i < 10; i++) begin
            eff_color[i] = color_reg[i];
        end
    end
`endif

    // Pixel selection: digit color, then binary rendering, then source pixel.
    always_comb begin
        pix       = s_axi4s_tdata;
        color_hit = eff_mode[1] && (s_axi4s_tcount >= eff_th) && (32'(s_axi4s_tnumber) <= 32'd9);
        if (color_hit) begin
            pix = '0;
            for (int unsigned i = 0; i < 10; i++) begin
                if (32'(s_axi4s_tnumber) == i) begin
                    pix = PIX_W'(eff_color[i]);
                end
            end
        end else if (eff_mode[0]) begin
            pix = s_axi4s_tbinary ? PIX_W'(24'hFFFFFF) : '0;
        end
    end

    // Single output stage; loads whenever the slot is empty or being drained.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi4s_tvalid <= 1'b0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
            m_axi4s_tdata  <= '0;
        end else if (s_axi4s_tready) begin
            m_axi4s_tvalid <= s_axi4s_tvalid;
            if (s_accept) begin
                m_axi4s_tuser <= s_axi4s_tuser;
                m_axi4s_tlast <= s_axi4s_tlast;
                m_axi4s_tdata <= pix;
            end
        end
    end

endmodule

// File: tb/tb_video_mnist_colorizer.sv
// Directed self-checking bench for video_mnist_colorizer (default parameters).
module tb_video_mnist_colorizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:0]  s_tuser;
    logic        s_tlast;
    logic [3:0]  s_tnumber;
    logic [0:0]  s_tcount;
    logic [31:0] s_tdata;
    logic        s_tbinary;
    logic        s_tvalid;
    logic        s_tready;
    logic [0:0]  m_tuser;
    logic        m_tlast;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_mnist_colorizer dut (
        .aclk            (clk),
        .aresetn         (rst_n),
        .s_axi4s_tuser   (s_tuser),
        .s_axi4s_tlast   (s_tlast),
        .s_axi4s_tnumber (s_tnumber),
        .s_axi4s_tcount  (s_tcount),
        .s_axi4s_tdata   (s_tdata),
        .s_axi4s_tbinary (s_tbinary),
        .s_axi4s_tvalid  (s_tvalid),
        .s_axi4s_tready  (s_tready),
        .m_axi4s_tuser   (m_tuser),
        .m_axi4s_tlast   (m_tlast),
        .m_axi4s_tdata   (m_tdata),
        .m_axi4s_tvalid  (m_tvalid),
        .m_axi4s_tready  (m_tready),
        .s_wb_adr_i      (wb_adr),
        .s_wb_dat_i      (wb_dat_w),
        .s_wb_dat_o      (wb_dat_r),
        .s_wb_we_i       (wb_we),
        .s_wb_sel_i      (wb_sel),
        .s_wb_stb_i      (wb_stb),
        .s_wb_ack_o      (wb_ack)
    );

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge clk);
        wb_adr = adr; wb_dat_w = dat; wb_sel = sel; wb_we = 1'b1; wb_stb = 1'b1;
        @(posedge clk);
        #1;
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat, output logic ack);
        @(negedge clk);
        wb_adr = adr; wb_we = 1'b0; wb_stb = 1'b1;
        #1;
        dat = wb_dat_r;
        ack = wb_ack;
        wb_stb = 1'b0;
    endtask

    task automatic drive_beat(input logic user, input logic last, input logic [3:0] num,
                              input logic cnt, input logic [31:0] data, input logic bin);
        s_tuser = user; s_tlast = last; s_tnumber = num;
        s_tcount = cnt; s_tdata = data; s_tbinary = bin; s_tvalid = 1'b1;
    endtask

    // One accepted beat; returns #1 after the loading edge.
    task automatic send_beat(input logic user, input logic last, input logic [3:0] num,
                             input logic cnt, input logic [31:0] data, input logic bin);
        @(negedge clk);
        drive_beat(user, last, num, cnt, data, bin);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        a;
        rst_n = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
        drive_beat(1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tuser !== 1'b0 || m_tlast !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b data=%h user=%b last=%b required 0/0/0/0",
                     m_tvalid, m_tdata, m_tuser, m_tlast);
        end
        checks++;
        if (s_tready !== 1'b1) begin
            failures++; $display("FAIL reset_tready: got %b required 1", s_tready);
        end
        wb_read(8'h00, d, a);
        checks++;
        if (d !== 32'h2 || a !== 1'b1) begin
            failures++; $display("FAIL reset_mode: got %h ack=%b required 00000002 ack=1", d, a);
        end
        wb_read(8'h01, d, a);
        checks++;
        if (d !== 32'h1) begin
            failures++; $display("FAIL reset_th: got %h required 00000001", d);
        end
        wb_read(8'h11, d, a);
        checks++;
        if (d !== 32'h00804000) begin
            failures++; $display("FAIL reset_color1: got %h required 00804000", d);
        end
        wb_read(8'h19, d, a);
        checks++;
        if (d !== 32'h00FFFFFF) begin
            failures++; $display("FAIL reset_color9: got %h required 00FFFFFF", d);
        end
    endtask

    task automatic test_color;
        send_beat(1'b1, 1'b1, 4'd2, 1'b1, 32'h00202020, 1'b0);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h00FF0000) begin
            failures++;
            $display("FAIL color_digit2: valid=%b data=%h required 1/00FF0000", m_tvalid, m_tdata);
        end
        checks++;
        if (m_tuser !== 1'b1 || m_tlast !== 1'b1) begin
            failures++; $display("FAIL color_sideband: user=%b last=%b required 1/1", m_tuser, m_tlast);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++; $display("FAIL color_drain: valid=%b required 0", m_tvalid);
        end
    endtask

    task automatic test_threshold;
        send_beat(1'b1, 1'b0, 4'd2, 1'b0, 32'h00202020, 1'b1);
        checks++;
        if (m_tdata !== 32'h00202020) begin
            failures++; $display("FAIL th_below_passthru: got %h required 00202020", m_tdata);
        end
        wb_write(8'h00, 32'h1, 4'hF);
        send_beat(1'b1, 1'b0, 4'd2, 1'b0, 32'h00202020, 1'b1);
        checks++;
        if (m_tdata !== 32'h00FFFFFF) begin
            failures++; $display("FAIL binary_white: got %h required 00FFFFFF", m_tdata);
        end
        send_beat(1'b1, 1'b0, 4'd2, 1'b1, 32'h00202020, 1'b0);
        checks++;
        if (m_tdata !== 32'h00000000) begin
            failures++; $display("FAIL binary_black: got %h required 00000000", m_tdata);
        end
        wb_write(8'h00, 32'h3, 4'hF);
        send_beat(1'b1, 1'b0, 4'd5, 1'b1, 32'h00202020, 1'b1);
        checks++;
        if (m_tdata !== 32'h0000FF00) begin
            failures++; $display("FAIL color_over_binary: got %h required 0000FF00", m_tdata);
        end
        wb_write(8'h00, 32'h2, 4'hF);
    endtask

    task automatic test_invalid_digit;
        send_beat(1'b1, 1'b0, 4'd12, 1'b1, 32'h00202020, 1'b0);
        checks++;
        if (m_tdata !== 32'h00202020) begin
            failures++; $display("FAIL digit12_passthru: got %h required 00202020", m_tdata);
        end
        send_beat(1'b1, 1'b0, 4'd9, 1'b1, 32'h00202020, 1'b0);
        checks++;
        if (m_tdata !== 32'h00FFFFFF) begin
            failures++; $display("FAIL digit9_color: got %h required 00FFFFFF", m_tdata);
        end
    endtask

    task automatic test_wb_regs;
        logic [31:0] d;
        logic        a;
        wb_write(8'h13, 32'hAA123456, 4'b0111);
        wb_read(8'h13, d, a);
        checks++;
        if (d !== 32'h00123456) begin
            failures++; $display("FAIL color3_readback: got %h required 00123456", d);
        end
        wb_write(8'h14, 32'h00ABCDEF, 4'b0001);
        wb_read(8'h14, d, a);
        checks++;
        if (d !== 32'h00FFFFEF) begin
            failures++; $display("FAIL color4_bytemask: got %h required 00FFFFEF", d);
        end
        wb_write(8'h05, 32'hFFFFFFFF, 4'hF);
        wb_read(8'h05, d, a);
        checks++;
        if (d !== 32'h0 || a !== 1'b1) begin
            failures++; $display("FAIL unmapped_read: got %h ack=%b required 00000000 ack=1", d, a);
        end
        send_beat(1'b1, 1'b0, 4'd3, 1'b1, 32'h00202020, 1'b0);
        checks++;
        if (m_tdata !== 32'h00123456) begin
            failures++; $display("FAIL color3_pixel: got %h required 00123456", m_tdata);
        end
    endtask

    task automatic test_same_cycle;
        logic [31:0] d;
        logic        a;
        logic [31:0] exp_mid;
        @(negedge clk);
        drive_beat(1'b1, 1'b0, 4'd2, 1'b1, 32'h00202020, 1'b0);
        wb_adr = 8'h00; wb_dat_w = 32'h0; wb_sel = 4'hF; wb_we = 1'b1; wb_stb = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        checks++;
        if (m_tdata !== 32'h00FF0000) begin
            failures++; $display("FAIL same_cycle_old_mode: got %h required 00FF0000", m_tdata);
        end
        wb_read(8'h00, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++; $display("FAIL mode_cleared: got %h required 00000000", d);
        end
`ifdef VIDEO_MNIST_COLOR_FRAME_SYNC_EN
        exp_mid = 32'h00FF0000;
`else
        exp_mid = 32'h00202020;
`endif
        send_beat(1'b0, 1'b0, 4'd2, 1'b1, 32'h00202020, 1'b0);
        checks++;
        if (m_tdata !== exp_mid) begin
            failures++; $display("FAIL mid_frame_mode: got %h required %h", m_tdata, exp_mid);
        end
        send_beat(1'b1, 1'b0, 4'd2, 1'b1, 32'h00202020, 1'b0);
        checks++;
        if (m_tdata !== 32'h00202020) begin
            failures++; $display("FAIL new_frame_mode: got %h required 00202020", m_tdata);
        end
        wb_write(8'h00, 32'h2, 4'hF);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        m_tready = 1'b0;
        send_beat(1'b1, 1'b0, 4'd2, 1'b1, 32'h00202020, 1'b0);
        @(negedge clk);
        drive_beat(1'b1, 1'b0, 4'd6, 1'b1, 32'h00303030, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 32'h00FF0000) begin
                failures++;
                $display("FAIL hold_stable[%0d]: tready=%b valid=%b data=%h required 0/1/00FF0000",
                         i, s_tready, m_tvalid, m_tdata);
            end
        end
        @(negedge clk);
        m_tready = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b1) begin
            failures++; $display("FAIL release_tready: got %b required 1", s_tready);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h000000FF) begin
            failures++;
            $display("FAIL swap_beat: valid=%b data=%h required 1/000000FF", m_tvalid, m_tdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++; $display("FAIL swap_drain: valid=%b required 0", m_tvalid);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        logic        a;
        wb_write(8'h00, 32'h1, 4'hF);
        @(negedge clk);
        m_tready = 1'b0;
        send_beat(1'b1, 1'b0, 4'd2, 1'b1, 32'h00202020, 1'b1);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h00FFFFFF) begin
            failures++;
            $display("FAIL pre_reset_beat: valid=%b data=%h required 1/00FFFFFF", m_tvalid, m_tdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_drop: valid=%b data=%h required 0/00000000", m_tvalid, m_tdata);
        end
        wb_read(8'h00, d, a);
        checks++;
        if (d !== 32'h2) begin
            failures++; $display("FAIL reset_mode_restore: got %h required 00000002", d);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_tready = 1'b1;
    endtask

    task automatic test_stream;
        localparam int W = 64;
        localparam int H = 16;
        localparam int N = W * H;
        int     tx = 0;
        int     rx = 0;
        int     cyc = 0;
        logic   acc;
        logic   take;
        logic   holding = 1'b0;
        wb_write(8'h00, 32'h0, 4'hF);
        while (rx < N && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            m_tready = ($urandom_range(0, 3) != 0);
            if (tx < N && (holding || $urandom_range(0, 3) != 0)) begin
                drive_beat(tx == 0, (tx % W) == W - 1, 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), tx, 1'($urandom_range(0, 1)));
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            acc  = s_tvalid && s_tready;
            take = m_tvalid && m_tready;
            if (take) begin
                checks++;
                if (m_tdata !== rx || m_tuser !== (rx == 0) || m_tlast !== ((rx % W) == W - 1)) begin
                    failures++;
                    $display("FAIL stream_beat[%0d]: data=%h user=%b last=%b required %h/%b/%b",
                             rx, m_tdata, m_tuser, m_tlast, rx, rx == 0, (rx % W) == W - 1);
                end
                rx++;
            end
            if (acc) begin
                tx++;
                holding = 1'b0;
            end else begin
                holding = s_tvalid;
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        checks++;
        if (rx != N || tx != N) begin
            failures++; $display("FAIL stream_count: sent=%0d received=%0d required %0d", tx, rx, N);
        end
    endtask

    initial begin
        test_reset;
        test_color;
        test_threshold;
        test_invalid_digit;
        test_wb_regs;
        test_same_cycle;
        test_back_to_back;
        test_reset_midframe;
        test_stream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
